// File: rtl/cdb_writeback_arbiter_if.sv
// Requester push bus and the three registered ROB writeback ports of cdb_writeback_arbiter.
// The arbiter uses the slave modport; the execution-unit/ROB side uses master.
interface cdb_writeback_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [5*NUM_REQ-1:0]  req_vregid;
  logic [32*NUM_REQ-1:0] req_val;
  logic [NUM_REQ-1:0]    req_ready;

  logic        writeback1_en;
  logic [4:0]  writeback1_vregid;
  logic [31:0] writeback1_val;
  logic        writeback2_en;
  logic [4:0]  writeback2_vregid;
  logic [31:0] writeback2_val;
  logic        writeback3_en;
  logic [4:0]  writeback3_vregid;
  logic [31:0] writeback3_val;

  modport master (
    output req_valid, req_vregid, req_val,
    input  req_ready,
    input  writeback1_en, writeback1_vregid, writeback1_val,
    input  writeback2_en, writeback2_vregid, writeback2_val,
    input  writeback3_en, writeback3_vregid, writeback3_val
  );

  modport slave (
    input  req_valid, req_vregid, req_val,
    output req_ready,
    output writeback1_en, writeback1_vregid, writeback1_val,
    output writeback2_en, writeback2_vregid, writeback2_val,
    output writeback3_en, writeback3_vregid, writeback3_val
  );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin CDB writeback arbiter: per-requester FIFOs drained onto three registered ROB ports.
// Defining CDB_BYPASS_EN lets an empty FIFO's incoming result be granted in the same cycle.
module cdb_writeback_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hci_rdy_i,
  input  logic flush_i,
  cdb_writeback_arbiter_if.slave bus
);

  localparam int RW  = $clog2(NUM_REQ);
  localparam int RW1 = RW + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NWB = 3;

  typedef struct packed {
    logic [4:0]  vregid;
    logic [31:0] val;
  } entry_t;

  entry_t         mem_q   [NUM_REQ][DEPTH];
  logic [PW-1:0]  head_q  [NUM_REQ];
  logic [PW-1:0]  head_d  [NUM_REQ];
  logic [PW-1:0]  tail_q  [NUM_REQ];
  logic [PW-1:0]  tail_d  [NUM_REQ];
  logic [CW-1:0]  count_q [NUM_REQ];
  logic [CW-1:0]  count_d [NUM_REQ];
  logic [RW-1:0]  rr_ptr_q;
  logic [RW-1:0]  rr_ptr_d;
  logic [NWB-1:0] wb_en_q;
  logic [NWB-1:0] wb_en_d;
  entry_t         wb_q [NWB];
  entry_t         wb_d [NWB];

  logic               run_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] nonempty_s;
  logic [NUM_REQ-1:0] cand_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] pop_s;
  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] bypass_s;
  entry_t             in_s   [NUM_REQ];
  entry_t             head_s [NUM_REQ];
  logic [NWB-1:0]     slot_use_s;
  logic [RW-1:0]      slot_sel_s [NWB];
  logic [1:0]         n_grant_s;
  logic [RW-1:0]      last_s;
  logic [RW-1:0]      scan_idx_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1'b1);
  endfunction

  // NUM_REQ need not be a power of two, so the wrap is an explicit subtract.
  function automatic logic [RW-1:0] rr_add(input logic [RW-1:0] base, input int ofs);
    logic [RW1-1:0] sum;
    sum = {1'b0, base} + RW1'(ofs);
    sum = (sum >= RW1'(NUM_REQ)) ? sum - RW1'(NUM_REQ) : sum;
    return sum[RW-1:0];
  endfunction

  assign run_s = hci_rdy_i & ~flush_i;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign in_s[gi].vregid = bus.req_vregid[5*gi +: 5];
    assign in_s[gi].val    = bus.req_val[32*gi +: 32];
    assign head_s[gi]      = mem_q[gi][head_q[gi]];
    assign nonempty_s[gi]  = (count_q[gi] != '0);
    assign ready_s[gi]     = run_s & (count_q[gi] < CW'(DEPTH));
  end

  assign bus.req_ready = ready_s;

`ifdef CDB_BYPASS_EN
  assign cand_s = nonempty_s | (bus.req_valid & ready_s);
`else
  assign cand_s = nonempty_s;
`endif

  // A granted empty FIFO can only be a bypass; its input is forwarded, not stored.
  assign pop_s    = grant_s & nonempty_s;
  assign bypass_s = grant_s & ~nonempty_s;
  assign push_s   = bus.req_valid & ready_s & ~bypass_s;

  // Round-robin scan from rr_ptr_q: the first three candidates take writeback ports 1..3 in order.
  always_comb begin
    grant_s    = '0;
    slot_use_s = '0;
    n_grant_s  = 2'd0;
    last_s     = rr_ptr_q;
    scan_idx_s = rr_ptr_q;
    for (int k = 0; k < NWB; k++) begin
      slot_sel_s[k] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = rr_add(rr_ptr_q, k);
      if (cand_s[scan_idx_s] && (n_grant_s != 2'd3)) begin
        grant_s[scan_idx_s]   = 1'b1;
        slot_use_s[n_grant_s] = 1'b1;
        slot_sel_s[n_grant_s] = scan_idx_s;
        n_grant_s             = n_grant_s + 2'd1;
        last_s                = scan_idx_s;
      end else begin
        last_s = last_s;
      end
    end
    if (|grant_s) begin
      rr_ptr_d = rr_add(last_s, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Writeback register next state: stored head, or the live input when bypassed.
  always_comb begin
    wb_en_d = slot_use_s;
    for (int k = 0; k < NWB; k++) begin
      if (!slot_use_s[k]) begin
        wb_d[k] = '0;
      end else if (nonempty_s[slot_sel_s[k]]) begin
        wb_d[k] = head_s[slot_sel_s[k]];
      end else begin
        wb_d[k] = in_s[slot_sel_s[k]];
      end
    end
  end

  // FIFO pointer and occupancy next state; push and pop together leave the count unchanged.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      count_d[i] = count_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
      head_d[i]  = pop_s[i]  ? ptr_inc(head_q[i]) : head_q[i];
      tail_d[i]  = push_s[i] ? ptr_inc(tail_q[i]) : tail_q[i];
    end
  end

  // Control state: rst beats flush, flush only acts with hci_rdy, and hci_rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= '0;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
      wb_en_q  <= '0;
      for (int k = 0; k < NWB; k++) begin
        wb_q[k] <= '0;
      end
    end else if (hci_rdy_i && flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= '0;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
      wb_en_q  <= '0;
    end else if (hci_rdy_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= count_d[i];
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      wb_en_q  <= wb_en_d;
      for (int k = 0; k < NWB; k++) begin
        wb_q[k] <= wb_d[k];
      end
    end
  end

  // FIFO storage: written only by an accepted push, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) begin
        mem_q[i][tail_q[i]] <= in_s[i];
      end
    end
  end

  assign bus.writeback1_en     = wb_en_q[0];
  assign bus.writeback1_vregid = wb_q[0].vregid;
  assign bus.writeback1_val    = wb_q[0].val;
  assign bus.writeback2_en     = wb_en_q[1];
  assign bus.writeback2_vregid = wb_q[1].vregid;
  assign bus.writeback2_val    = wb_q[1].val;
  assign bus.writeback3_en     = wb_en_q[2];
  assign bus.writeback3_vregid = wb_q[2].vregid;
  assign bus.writeback3_val    = wb_q[2].val;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter: directed scenarios then random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_cdb_writeback_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 2;
`ifdef CDB_BYPASS_EN
  localparam int BYPASS = 1;
`else
  localparam int BYPASS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic hci_rdy;
  logic flush;

  always #5 clk = ~clk;

  cdb_writeback_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cdb_writeback_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .hci_rdy_i (hci_rdy),
    .flush_i   (flush),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [NUM_REQ-1:0]    drv_valid;
  logic [5*NUM_REQ-1:0]  drv_vid;
  logic [32*NUM_REQ-1:0] drv_val;

  // Reference model: one queue of {vregid,val} per requester plus the expected port registers.
  logic [36:0] mq [NUM_REQ][$];
  int          m_rr = 0;
  logic        exp_en  [3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0]  exp_vid [3] = '{5'd0, 5'd0, 5'd0};
  logic [31:0] exp_val [3] = '{32'd0, 32'd0, 32'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_drv();
    drv_valid = '0;
    drv_vid   = '0;
    drv_val   = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] vid, input logic [31:0] val);
    drv_valid[i]       = 1'b1;
    drv_vid[5*i +: 5]  = vid;
    drv_val[32*i +: 32] = val;
  endtask

  task automatic rand_drv();
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_valid[i]        = ($urandom_range(0, 3) != 0);
      drv_vid[5*i +: 5]   = 5'($urandom);
      drv_val[32*i +: 32] = $urandom;
    end
  endtask

  task automatic model_clear();
    for (int q = 0; q < NUM_REQ; q++) mq[q].delete();
    m_rr = 0;
    for (int k = 0; k < 3; k++) exp_en[k] = 1'b0;
  endtask

  task automatic model_edge(input logic h, input logic f, input logic r, input logic [NUM_REQ-1:0] mrdy);
    int n;
    int last;
    int i;
    bit byp [NUM_REQ];
    logic [36:0] e;
    if (r) begin
      model_clear();
      for (int k = 0; k < 3; k++) begin
        exp_vid[k] = 5'd0;
        exp_val[k] = 32'd0;
      end
    end else if (h && f) begin
      model_clear();
    end else if (h) begin
      n = 0;
      last = -1;
      for (int q = 0; q < NUM_REQ; q++) byp[q] = 1'b0;
      for (int k = 0; k < 3; k++) exp_en[k] = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (m_rr + k) % NUM_REQ;
        if (n < 3 && mq[i].size() > 0) begin
          e = mq[i].pop_front();
          exp_en[n] = 1'b1; exp_vid[n] = e[36:32]; exp_val[n] = e[31:0];
          n++; last = i;
        end else if (n < 3 && BYPASS != 0 && drv_valid[i] && mrdy[i]) begin
          exp_en[n] = 1'b1; exp_vid[n] = drv_vid[5*i +: 5]; exp_val[n] = drv_val[32*i +: 32];
          byp[i] = 1'b1;
          n++; last = i;
        end
      end
      if (last >= 0) m_rr = (last + 1) % NUM_REQ;
      for (int q = 0; q < NUM_REQ; q++) begin
        if (drv_valid[q] && mrdy[q] && !byp[q]) mq[q].push_back({drv_vid[5*q +: 5], drv_val[32*q +: 32]});
      end
    end
  endtask

  task automatic check_outputs();
    logic        a_en  [3];
    logic [4:0]  a_vid [3];
    logic [31:0] a_val [3];
    a_en[0] = bus.writeback1_en; a_vid[0] = bus.writeback1_vregid; a_val[0] = bus.writeback1_val;
    a_en[1] = bus.writeback2_en; a_vid[1] = bus.writeback2_vregid; a_val[1] = bus.writeback2_val;
    a_en[2] = bus.writeback3_en; a_vid[2] = bus.writeback3_vregid; a_val[2] = bus.writeback3_val;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wb%0d_en", k + 1), 32'(a_en[k]), 32'(exp_en[k]));
      if (exp_en[k]) begin
        chk($sformatf("wb%0d_vregid", k + 1), 32'(a_vid[k]), 32'(exp_vid[k]));
        chk($sformatf("wb%0d_val", k + 1), a_val[k], exp_val[k]);
      end
    end
  endtask

  // One clock: drive at the falling edge, check ready, update the model at the rising edge, check outputs.
  task automatic step(input logic h, input logic f, input logic r);
    logic [NUM_REQ-1:0] mrdy;
    @(negedge clk);
    hci_rdy = h; flush = f; rst = r;
    bus.req_valid = drv_valid; bus.req_vregid = drv_vid; bus.req_val = drv_val;
    for (int q = 0; q < NUM_REQ; q++) mrdy[q] = h && !f && (mq[q].size() < DEPTH);
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(mrdy));
    @(posedge clk);
    model_edge(h, f, r, mrdy);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       o1_en, o1_en2, o2_en, o2_en2;
    logic [4:0] o1_vid, o2_vid;
    logic [31:0] o1_val, o2_val;
    int s;
    bit acc;

    rst = 1'b1; hci_rdy = 1'b1; flush = 1'b0;
    clear_drv();
    bus.req_valid = '0; bus.req_vregid = '0; bus.req_val = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_wb1_vregid", 32'(bus.writeback1_vregid), 32'd0);
    chk("rst_wb2_val", bus.writeback2_val, 32'd0);
    chk("rst_wb3_val", bus.writeback3_val, 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'hF);

    // Single push with its latency
    set_req(0, 5'd7, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0);
    o1_en = bus.writeback1_en; o1_en2 = bus.writeback2_en;
    o1_vid = bus.writeback1_vregid; o1_val = bus.writeback1_val;
    clear_drv();
    step(1'b1, 1'b0, 1'b0);
    o2_en = bus.writeback1_en; o2_en2 = bus.writeback2_en;
    o2_vid = bus.writeback1_vregid; o2_val = bus.writeback1_val;
    chk("single_en_push_edge", 32'(o1_en), 32'(BYPASS));
    chk("single_en_next_edge", 32'(o2_en), 32'(1 - BYPASS));
    chk("single_vregid", 32'((BYPASS != 0) ? o1_vid : o2_vid), 32'd7);
    chk("single_val", (BYPASS != 0) ? o1_val : o2_val, 32'hDEAD_BEEF);
    chk("single_wb2_en", 32'((BYPASS != 0) ? o1_en2 : o2_en2), 32'd0);

    // Four busy FIFOs from rr_ptr=0, two entries each
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(10 + i), 32'h1000 + i);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(20 + i), 32'h2000 + i);
    step(1'b1, 1'b0, 1'b0);
    clear_drv();
    repeat (4) step(1'b1, 1'b0, 1'b0);

    // Fill FIFO 2 while the ports stay busy; the held third entry must not be lost
    step(1'b1, 1'b1, 1'b0);
    s = 3;
    for (int c = 0; c < 14; c++) begin
      rand_drv();
      set_req(0, 5'($urandom), $urandom);
      set_req(1, 5'($urandom), $urandom);
      set_req(3, 5'($urandom), $urandom);
      if (s <= 5) set_req(2, 5'(s), 32'h3300 + s);
      else drv_valid[2] = 1'b0;
      acc = (mq[2].size() < DEPTH);
      step(1'b1, 1'b0, 1'b0);
      if (s <= 5 && acc) s++;
    end
    clear_drv();
    repeat (6) step(1'b1, 1'b0, 1'b0);
    chk("fill_fifo2_all_accepted", 32'(s), 32'd6);

    // hci_rdy low for 5 cycles while vregid 9 sits on writeback1
    step(1'b1, 1'b1, 1'b0);
    set_req(0, 5'd9, 32'h0000_9999);
    step(1'b1, 1'b0, 1'b0);
    clear_drv();
    repeat (1 - BYPASS) step(1'b1, 1'b0, 1'b0);
    chk("stall_wb1_vregid", 32'(bus.writeback1_vregid), 32'd9);
    for (int c = 0; c < 5; c++) begin
      rand_drv();
      step(1'b0, 1'(c % 2), 1'b0);
    end
    clear_drv();
    step(1'b1, 1'b0, 1'b0);
    chk("stall_release_wb1_en", 32'(bus.writeback1_en), 32'd0);

    // Flush with entries in flight and a push offered in the flush cycle
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 1), 32'h4400 + i);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 5), 32'h5500 + i);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 12), 32'h6600 + i);
    step(1'b1, 1'b1, 1'b0);
    chk("flush_all_en", 32'({bus.writeback3_en, bus.writeback2_en, bus.writeback1_en}), 32'd0);
    clear_drv();
    step(1'b1, 1'b0, 1'b0);
    chk("flush_dropped_input", 32'({bus.writeback3_en, bus.writeback2_en, bus.writeback1_en}), 32'd0);

    // Random traffic with occasional stalls, flushes and resets
    for (int c = 0; c < 800; c++) begin
      rand_drv();
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 199) == 0));
    end
    clear_drv();
    repeat (6) step(1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
